// File: rtl/lt_sweep_checker.sv
// Exhaustive sweep driver and checker for a W-bit unsigned less-than comparator.
// Holds each operand pair for HOLD cycles, then checks lt_in against i0<i1.
module lt_sweep_checker #(
  parameter int W    = 2,
  parameter int HOLD = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           lt_in,
  output logic [W-1:0]   i0,
  output logic [W-1:0]   i1,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_cnt,
  output logic           fe_vld,
  output logic [W-1:0]   fe_i0,
  output logic [W-1:0]   fe_i1,
  output logic [1:0]     state_dbg
);

  localparam int HW = (HOLD > 2) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [2*W-1:0]  vec;
  logic [HW-1:0]   hcnt;

  logic            exp_lt;
  logic            mismatch;
  logic [2*W:0]    err_next;

  assign i0        = vec[2*W-1:W];
  assign i1        = vec[W-1:0];
  assign state_dbg = state;

  // Golden result and the error count as it will stand after this sample.
  always_comb begin
    exp_lt   = (i0 < i1);
    mismatch = (lt_in != exp_lt);
    err_next = err_cnt;
    if (mismatch && (err_cnt != {(2*W+1){1'b1}}))
      err_next = err_cnt + 1'b1;
  end

  // start is a level request, honoured only on an edge where state is IDLE or DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      vec     <= '0;
      hcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      fe_vld  <= 1'b0;
      fe_i0   <= '0;
      fe_i1   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            vec     <= '0;
            hcnt    <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            fe_vld  <= 1'b0;
            fe_i0   <= '0;
            fe_i1   <= '0;
          end
        end
        RUN: begin
          if (hcnt != HLAST) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            err_cnt <= err_next;
            if (mismatch && !fe_vld) begin
              fe_vld <= 1'b1;
              fe_i0  <= i0;
              fe_i1  <= i1;
            end
            if (vec != {(2*W){1'b1}}) begin
              vec  <= vec + 1'b1;
              hcnt <= '0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lt_sweep_checker.sv
// Directed bench for lt_sweep_checker (W=2, HOLD=4) driving a modelled comparator.
module tb_lt_sweep_checker;

  localparam int W    = 2;
  localparam int HOLD = 4;
  localparam int NCYC = (1 << (2 * W)) * HOLD;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic           lt_in;
  logic [W-1:0]   i0, i1;
  logic           busy, done, pass;
  logic [2*W:0]   err_cnt;
  logic           fe_vld;
  logic [W-1:0]   fe_i0, fe_i1;
  logic [1:0]     state_dbg;

  int n_cmp;
  int n_err;
  int mode;  // 0 golden, 1 stuck-0, 2 inverted, 3 stuck-1

  lt_sweep_checker #(.W(W), .HOLD(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .lt_in(lt_in),
    .i0(i0), .i1(i1), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fe_vld(fe_vld), .fe_i0(fe_i0), .fe_i1(fe_i1),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator under test, modelled with selectable faults.
  always_comb begin
    lt_in = 1'b0;
    case (mode)
      0: lt_in = (i0 < i1);
      1: lt_in = 1'b0;
      2: lt_in = !(i0 < i1);
      3: lt_in = 1'b1;
      default: lt_in = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {busy, done, pass, fe_vld, i0, i1, fe_i0, fe_i1}, 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // Starts a sweep and follows it to done, checking the vector order and latency.
  task automatic run_sweep(input bit spam);
    bit seq_ok;
    int cycles;
    seq_ok = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("start_clears", {29'd0, done, pass, fe_vld}, 32'd0);
    check("start_err_cnt", 32'(err_cnt), 32'd0);
    cycles = 0;
    while (!done && cycles < 4 * NCYC) begin
      if (busy !== 1'b1 || {i0, i1} !== 4'(cycles / HOLD)) seq_ok = 1'b0;
      if (spam) start = cycles[0];
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check("vec_seq", 32'(seq_ok), 32'd1);
    check("latency", cycles, NCYC);
    check("done_state", {29'd0, done, busy, 1'b0} | 32'(state_dbg), 32'd4 | 32'd2);
  endtask

  typedef struct {
    int          md;
    logic [4:0]  exp_err;
    logic        exp_pass;
    logic        exp_fe_vld;
    logic [1:0]  exp_fe_i0;
    logic [1:0]  exp_fe_i1;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [4:0] held_err;
    int guard;
    n_cmp = 0; n_err = 0; mode = 0;
    start = 1'b0;

    tbl[0] = '{0, 5'd0,  1'b1, 1'b0, 2'd0, 2'd0};
    tbl[1] = '{1, 5'd6,  1'b0, 1'b1, 2'd0, 2'd1};
    tbl[2] = '{2, 5'd16, 1'b0, 1'b1, 2'd0, 2'd0};
    tbl[3] = '{0, 5'd0,  1'b1, 1'b0, 2'd0, 2'd0};
    tbl[4] = '{3, 5'd10, 1'b0, 1'b1, 2'd0, 2'd0};

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1; check_all_zero("in_reset");
    @(negedge clk); reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1; check_all_zero("idle_no_start");

    for (int t = 0; t < 5; t++) begin
      mode = tbl[t].md;
      run_sweep(1'b0);
      check($sformatf("err_cnt_%0d", t), 32'(err_cnt), 32'(tbl[t].exp_err));
      check($sformatf("pass_%0d", t), 32'(pass), 32'(tbl[t].exp_pass));
      check($sformatf("fe_vld_%0d", t), 32'(fe_vld), 32'(tbl[t].exp_fe_vld));
      check($sformatf("fe_pair_%0d", t), 32'({fe_i0, fe_i1}),
            32'({tbl[t].exp_fe_i0, tbl[t].exp_fe_i1}));
    end

    // DONE must hold its results while start stays low.
    held_err = err_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("done_hold", {26'd0, done, pass, 4'd0} | 32'(err_cnt), {26'd0, 1'b1, 1'b0, 4'd0} | 32'(held_err));

    // start toggled throughout RUN must not restart the sweep.
    mode = 0;
    run_sweep(1'b1);
    check("spam_pass", 32'(pass), 32'd1);

    // Asynchronous reset in the middle of a failing sweep.
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    guard = 0;
    while ({i0, i1} != 4'd7 && guard < 2 * NCYC) begin
      @(posedge clk); #1; guard++;
    end
    check("reach_vec7", 32'({i0, i1}), 32'd7);
    @(posedge clk); #2;
    check("pre_reset_err", 32'(err_cnt), 32'd4);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk); reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1; check_all_zero("post_reset_idle");
    mode = 0;
    run_sweep(1'b0);
    check("post_reset_pass", 32'({pass, fe_vld}), 32'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
